// File: rtl/jtag_bitbang_bridge.sv
// rtl/jtag_bitbang_bridge.sv - remote-bitbang command stream to JTAG pin bridge
module jtag_bitbang_bridge #(
  parameter int TICK_DELAY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       init_done_i,
  input  logic       cmd_valid_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  input  logic       rsp_ready_i,
  output logic       jtag_tck_o,
  output logic       jtag_tms_o,
  output logic       jtag_tdi_o,
  output logic       jtag_trst_no,
  input  logic       jtag_tdo_i,
  input  logic       jtag_tdo_driven_i,
  output logic       exit_o
);

  localparam int TW = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DELAY);

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_ONE  = 8'h31;

  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          trst_n_q, trst_n_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          exit_q, exit_d;
  logic [TW-1:0] tick_q, tick_d;

  logic accept;
  logic [2:0] pin_val;

  // Once quit has been seen the bridge swallows everything so the host never stalls.
  assign cmd_ready_o = exit_q |
                       (enable_i & init_done_i & (tick_q == '0) & ~rsp_valid_q);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign pin_val     = 3'(cmd_data_i - CH_ZERO);

  // Next-state: command decode, response handshake and inter-command spacing.
  always_comb begin
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_n_d    = trst_n_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    exit_d      = exit_q;
    tick_d      = tick_q;

    // Drain is allowed regardless of enable so a pending response is never stuck.
    if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    if (tick_q != '0 && enable_i) begin
      tick_d = tick_q - 1'b1;
    end

    if (accept && !exit_q) begin
      tick_d = TICK_LOAD;
      unique case (cmd_data_i)
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37: begin
          tck_d = pin_val[2];
          tms_d = pin_val[1];
          tdi_d = pin_val[0];
        end
        8'h52: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = (jtag_tdo_driven_i && jtag_tdo_i) ? CH_ONE : CH_ZERO;
        end
        8'h72, 8'h73: trst_n_d = 1'b1;
        8'h74, 8'h75: trst_n_d = 1'b0;
        8'h51:        exit_d   = 1'b1;
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset to the idle pin state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= CH_ZERO;
      exit_q      <= 1'b0;
      tick_q      <= '0;
    end else begin
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_n_q    <= trst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      exit_q      <= exit_d;
      tick_q      <= tick_d;
    end
  end

  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_n_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign exit_o       = exit_q;

endmodule

// File: tb/tb_jtag_bitbang_bridge.sv
// tb/tb_jtag_bitbang_bridge.sv - scoreboard bench for jtag_bitbang_bridge
module tb_jtag_bitbang_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       init_done;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       tck, tms, tdi, trst_n;
  logic       tdo, tdo_driven;
  logic       exit_f;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  jtag_bitbang_bridge #(.TICK_DELAY(1)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .enable_i          (enable),
    .init_done_i       (init_done),
    .cmd_valid_i       (cmd_valid),
    .cmd_data_i        (cmd_data),
    .cmd_ready_o       (cmd_ready),
    .rsp_valid_o       (rsp_valid),
    .rsp_data_o        (rsp_data),
    .rsp_ready_i       (rsp_ready),
    .jtag_tck_o        (tck),
    .jtag_tms_o        (tms),
    .jtag_tdi_o        (tdi),
    .jtag_trst_no      (trst_n),
    .jtag_tdo_i        (tdo),
    .jtag_tdo_driven_i (tdo_driven),
    .exit_o            (exit_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // pins packed as {tck,tms,tdi,trst_n}
  task automatic chk_pins(input string name, input logic [3:0] exp);
    chk(name, {28'd0, tck, tms, tdi, trst_n}, {28'd0, exp});
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // monitor: every completed response handshake is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {24'd0, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; init_done = 1'b1;
    cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
    tdo = 1'b0; tdo_driven = 1'b1;
    repeat (2) @(negedge clk);
    chk_pins("reset_pins", 4'b0001);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", {24'd0, rsp_data}, 32'h30);
    chk("reset_exit", {31'd0, exit_f}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // '5' -> tck=1 tms=0 tdi=1, one-cycle gap
    send(8'h35);
    @(negedge clk);
    chk_pins("pins_after_5", 4'b1011);
    chk("ready_gap", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_gap", {31'd0, cmd_ready}, 32'd1);

    // 'R' with TDO=1 driven; hold the response for three cycles
    tdo = 1'b1; tdo_driven = 1'b1;
    exp_q.push_back(8'h31);
    send(8'h52);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_hold_data", {24'd0, rsp_data}, 32'h31);
      chk("rsp_hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);

    // 'R' with TDO not driven reads '0'
    tdo = 1'b1; tdo_driven = 1'b0;
    exp_q.push_back(8'h30);
    send(8'h52);
    repeat (3) @(negedge clk);

    // TRST control and ignored bytes
    send(8'h74);
    @(negedge clk);
    chk_pins("trst_low", 4'b1010);
    send(8'h72);
    @(negedge clk);
    chk_pins("trst_high", 4'b1011);
    send(8'h42);
    send(8'h78);
    send(8'h62);
    repeat (2) @(negedge clk);
    chk_pins("ignored_bytes", 4'b1011);
    chk("ignored_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // init_done low blocks acceptance
    @(posedge clk); #1;
    init_done = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h32;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("init_block_ready", {31'd0, cmd_ready}, 32'd0);
      chk_pins("init_block_pins", 4'b1011);
    end
    @(posedge clk); #1 init_done = 1'b1;
    @(negedge clk);
    chk("init_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk_pins("pins_after_2", 4'b0101);

    // quit, then everything is swallowed
    send(8'h51);
    @(negedge clk);
    chk("exit_set", {31'd0, exit_f}, 32'd1);
    chk("exit_ready", {31'd0, cmd_ready}, 32'd1);
    send(8'h37);
    @(negedge clk);
    chk_pins("after_exit_pins", 4'b0101);
    chk("exit_sticky", {31'd0, exit_f}, 32'd1);

    // asynchronous reset mid-cycle
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("async_exit", {31'd0, exit_f}, 32'd0);
    chk_pins("async_pins", 4'b0001);
    chk("async_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
